// File: rtl/vga_sync_if.sv
// Pin-level bundle for the VGA sync decoder: raw sync inputs plus the decoded timing outputs.
// The source side drives the sync pins; the decoder side returns position, measurements and lock status.
interface vga_sync_if;
  logic       hSyncIn;
  logic       vSyncIn;
  logic [9:0] hPos;
  logic [9:0] vPos;
  logic [9:0] lineLen;
  logic [9:0] frameLines;
  logic       frameStart;
  logic       locked;
  logic       syncErr;
  logic [1:0] state_dbg;

  modport master (
    output hSyncIn, vSyncIn,
    input  hPos, vPos, lineLen, frameLines, frameStart, locked, syncErr, state_dbg
  );

  modport slave (
    input  hSyncIn, vSyncIn,
    output hPos, vPos, lineLen, frameLines, frameStart, locked, syncErr, state_dbg
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// Measures incoming VGA hsync/vsync timing and locks once enough consecutive frames
// match the nominal line length and line count.
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 521,
  parameter int LOCK_FRAMES = 2
) (
  input  logic      Clk,
  input  logic      vgaRst,
  vga_sync_if.slave bus
);

  localparam logic [1:0] SEARCH  = 2'd0;
  localparam logic [1:0] CHECK   = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  localparam logic [9:0] CNT_MAX   = 10'd1023;
  localparam logic [9:0] H_TOTAL_W = 10'(H_TOTAL);
  localparam logic [9:0] V_TOTAL_W = 10'(V_TOTAL);
  localparam logic [2:0] LOCK_W    = 3'(LOCK_FRAMES);

  // Synchronizer and falling-edge detector flops; sync stages idle high.
  logic h_meta_q, h_sync_q, h_last_q, h_ev_q;
  logic v_meta_q, v_sync_q, v_last_q, v_ev_q;
  logic h_meta_d, h_sync_d, h_last_d, h_ev_d;
  logic v_meta_d, v_sync_d, v_last_d, v_ev_d;

  logic [9:0] h_pos_q, h_pos_d;
  logic [9:0] v_pos_q, v_pos_d;
  logic [9:0] line_len_q, line_len_d;
  logic [9:0] frame_lines_q, frame_lines_d;
  logic       frame_start_q, frame_start_d;
  logic       sync_err_q, sync_err_d;
  logic       locked_q, locked_d;
  logic       line_bad_q, line_bad_d;
  logic [1:0] good_cnt_q, good_cnt_d;
  logic [1:0] state_q, state_d;

  logic       timeout;
  logic [9:0] meas_len;
  logic       len_bad;
  logic       bad_now;
  logic [9:0] frame_len;
  logic       frame_good;
  logic [2:0] good_next;

  always_comb begin
    h_meta_d = bus.hSyncIn;
    h_sync_d = h_meta_q;
    h_last_d = h_sync_q;
    h_ev_d   = h_last_q & ~h_sync_q;
    v_meta_d = bus.vSyncIn;
    v_sync_d = v_meta_q;
    v_last_d = v_sync_q;
    v_ev_d   = v_last_q & ~v_sync_q;
  end

  always_comb begin
    timeout    = (h_pos_q == CNT_MAX);
    meas_len   = timeout ? CNT_MAX : h_pos_q + 10'd1;
    len_bad    = h_ev_q & (meas_len != H_TOTAL_W);
    // The line closing on the same cycle as vsync belongs to the frame being judged.
    bad_now    = line_bad_q | len_bad;
    frame_len  = (v_pos_q == CNT_MAX) ? CNT_MAX : v_pos_q + {9'd0, h_ev_q};
    frame_good = ~bad_now & (frame_len == V_TOTAL_W);
    good_next  = {1'b0, good_cnt_q} + 3'd1;

    h_pos_d       = h_pos_q;
    v_pos_d       = v_pos_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    frame_start_d = 1'b0;
    sync_err_d    = 1'b0;
    line_bad_d    = line_bad_q;
    good_cnt_d    = good_cnt_q;
    state_d       = state_q;

    if (h_ev_q) begin
      line_len_d = meas_len;
      h_pos_d    = 10'd0;
    end else if (!timeout) begin
      h_pos_d = h_pos_q + 10'd1;
    end

    if (v_ev_q) begin
      frame_lines_d = frame_len;
      v_pos_d       = 10'd0;
      frame_start_d = 1'b1;
      line_bad_d    = 1'b0;
    end else begin
      if (h_ev_q && (v_pos_q != CNT_MAX)) v_pos_d = v_pos_q + 10'd1;
      line_bad_d = bad_now;
    end

    // A stalled hsync overrides any event seen in the same cycle.
    if (timeout) begin
      state_d    = SEARCH;
      v_pos_d    = 10'd0;
      good_cnt_d = 2'd0;
      sync_err_d = (state_q == LOCKED);
    end else begin
      case (state_q)
        SEARCH: begin
          if (v_ev_q) begin
            state_d    = CHECK;
            good_cnt_d = 2'd0;
          end
        end
        CHECK: begin
          if (v_ev_q) begin
            if (frame_good) begin
              good_cnt_d = (good_cnt_q == 2'd3) ? 2'd3 : good_next[1:0];
              if (good_next == LOCK_W) state_d = LOCKED;
            end else begin
              good_cnt_d = 2'd0;
            end
          end
        end
        LOCKED: begin
          if (len_bad || (v_ev_q && !frame_good)) begin
            sync_err_d = 1'b1;
            state_d    = SEARCH;
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge Clk or negedge vgaRst) begin
    if (!vgaRst) begin
      h_meta_q      <= 1'b1;
      h_sync_q      <= 1'b1;
      h_last_q      <= 1'b1;
      h_ev_q        <= 1'b0;
      v_meta_q      <= 1'b1;
      v_sync_q      <= 1'b1;
      v_last_q      <= 1'b1;
      v_ev_q        <= 1'b0;
      h_pos_q       <= 10'd0;
      v_pos_q       <= 10'd0;
      line_len_q    <= 10'd0;
      frame_lines_q <= 10'd0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
      locked_q      <= 1'b0;
      line_bad_q    <= 1'b0;
      good_cnt_q    <= 2'd0;
      state_q       <= SEARCH;
    end else begin
      h_meta_q      <= h_meta_d;
      h_sync_q      <= h_sync_d;
      h_last_q      <= h_last_d;
      h_ev_q        <= h_ev_d;
      v_meta_q      <= v_meta_d;
      v_sync_q      <= v_sync_d;
      v_last_q      <= v_last_d;
      v_ev_q        <= v_ev_d;
      h_pos_q       <= h_pos_d;
      v_pos_q       <= v_pos_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      frame_start_q <= frame_start_d;
      sync_err_q    <= sync_err_d;
      locked_q      <= locked_d;
      line_bad_q    <= line_bad_d;
      good_cnt_q    <= good_cnt_d;
      state_q       <= state_d;
    end
  end

  assign bus.hPos       = h_pos_q;
  assign bus.vPos       = v_pos_q;
  assign bus.lineLen    = line_len_q;
  assign bus.frameLines = frame_lines_q;
  assign bus.frameStart = frame_start_q;
  assign bus.locked     = locked_q;
  assign bus.syncErr    = sync_err_q;
  assign bus.state_dbg  = state_q;

endmodule
